// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_fifo                                                 |
// | Description : UART16550 receive buffer. Stores received characters with    |
// |               their parity/framing/break flags and produces the line       |
// |               status (data ready, overrun, error-in-FIFO, trigger,         |
// |               character timeout). FIFO mode holds DEPTH entries, 16450     |
// |               mode uses a single holding register.                         |
// | Optional    : `define UART_RX_TIMEOUT_EN to build the character-timeout    |
// |               counter; otherwise timeout is tied to 0.                     |
// | Ports       : clk, rst (async, active-high)                                |
// |               fifo_en, clr, trig_lvl        - FCR controls                 |
// |               push, din, pe_in/fe_in/bi_in  - receiver write side          |
// |               pop, ovr_clr                  - RBR / LSR read strobes       |
// |               baud_pulse                    - 16x baud tick                |
// |               dout, dout_pe/fe/bi           - show-ahead head entry        |
// |               empty, full, count, overrun, trig, err_in_fifo, timeout      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_rx_fifo #(
  parameter int DEPTH      = 16,
  parameter int AW         = 4,
  parameter int TOUT_TICKS = 640
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_en,
  input  logic          clr,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pe_in,
  input  logic          fe_in,
  input  logic          bi_in,
  input  logic          pop,
  input  logic          ovr_clr,
  input  logic [1:0]    trig_lvl,
  input  logic          baud_pulse,
  output logic [7:0]    dout,
  output logic          dout_pe,
  output logic          dout_fe,
  output logic          dout_bi,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overrun,
  output logic          trig,
  output logic          err_in_fifo,
  output logic          timeout
);

  localparam logic [AW:0] c_depth_cnt = (AW+1)'(DEPTH);
  localparam logic [AW:0] c_one       = (AW+1)'(1);

  logic [10:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [AW:0]   r_err_cnt;
  logic          r_overrun;
  logic          r_fifo_en_q;

  logic [10:0]   w_entry;
  logic [10:0]   w_head;
  logic          w_empty;
  logic          w_full;
  logic          w_flush;
  logic          w_do_pop;
  logic          w_do_write;
  logic          w_ovr_set;
  logic          w_overwrite;
  logic          w_err_inc;
  logic          w_err_dec;
  logic [AW:0]   w_trig_thr;

  // Entry layout: {bi, fe, pe, data}
  assign w_entry = {bi_in, fe_in, pe_in, din};
  assign w_head  = r_mem[r_rptr];
  assign w_empty = (r_count == '0);
  assign w_full  = fifo_en ? (r_count == c_depth_cnt) : (r_count == c_one);

  // Any mode change behaves like a receive-FIFO reset.
  assign w_flush = clr | (fifo_en != r_fifo_en_q);

  // A pop frees a slot, so push-while-full with a pop is a normal write.
  assign w_do_pop    = pop & ~w_empty & ~w_flush;
  assign w_do_write  = push & ~w_flush & (~w_full | w_do_pop);
  assign w_ovr_set   = push & ~w_flush & w_full & ~w_do_pop;
  // 16450 mode: the newest character replaces the holding register.
  assign w_overwrite = w_ovr_set & ~fifo_en;

  // An overwrite both removes the old head and inserts the new entry.
  assign w_err_inc = (w_do_write | w_overwrite) & (|w_entry[10:8]);
  assign w_err_dec = (w_do_pop   | w_overwrite) & (|w_head[10:8]);

  always_ff @(posedge clk) begin
    if (w_do_write) begin
      r_mem[r_wptr] <= w_entry;
    end else if (w_overwrite) begin
      r_mem[r_rptr] <= w_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_err_cnt   <= '0;
      r_overrun   <= 1'b0;
      // FCR resets to 16450 mode, so track that as the starting mode.
      r_fifo_en_q <= 1'b0;
    end else begin
      r_fifo_en_q <= fifo_en;

      if (w_flush) begin
        r_wptr    <= '0;
        r_rptr    <= '0;
        r_count   <= '0;
        r_err_cnt <= '0;
      end else begin
        if (w_do_write) begin
          r_wptr <= r_wptr + 1'b1;
        end
        if (w_do_pop) begin
          r_rptr <= r_rptr + 1'b1;
        end
        case ({w_do_write, w_do_pop})
          2'b10:   r_count <= r_count + c_one;
          2'b01:   r_count <= r_count - c_one;
          default: r_count <= r_count;
        endcase
        case ({w_err_inc, w_err_dec})
          2'b10:   r_err_cnt <= r_err_cnt + c_one;
          2'b01:   r_err_cnt <= r_err_cnt - c_one;
          default: r_err_cnt <= r_err_cnt;
        endcase
      end

      // Set has priority over the LSR-read clear.
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (ovr_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  always_comb begin
    w_trig_thr = (AW+1)'(1);
    case (trig_lvl)
      2'b00:   w_trig_thr = (AW+1)'(1);
      2'b01:   w_trig_thr = (AW+1)'(4);
      2'b10:   w_trig_thr = (AW+1)'(8);
      default: w_trig_thr = (AW+1)'(14);
    endcase
  end

  assign dout        = w_empty ? 8'h00 : w_head[7:0];
  assign dout_pe     = ~w_empty & w_head[8];
  assign dout_fe     = ~w_empty & w_head[9];
  assign dout_bi     = ~w_empty & w_head[10];
  assign empty       = w_empty;
  assign full        = w_full;
  assign count       = r_count;
  assign overrun     = r_overrun;
  assign trig        = fifo_en & (r_count >= w_trig_thr);
  assign err_in_fifo = (r_err_cnt != '0);

`ifdef UART_RX_TIMEOUT_EN
  localparam int c_tw = (TOUT_TICKS > 1) ? $clog2(TOUT_TICKS) : 1;
  localparam logic [c_tw-1:0] c_tout_max = c_tw'(TOUT_TICKS - 1);

  logic [c_tw-1:0] r_tout_cnt;
  logic            r_timeout;
  logic            w_tout_kick;

  // Any receive or read activity restarts the character-timeout window.
  assign w_tout_kick = push | w_do_pop | w_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tout_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_tout_kick || w_empty || !fifo_en) begin
        r_tout_cnt <= '0;
      end else if (baud_pulse && (r_tout_cnt != c_tout_max)) begin
        r_tout_cnt <= r_tout_cnt + c_tw'(1);
      end

      if (w_tout_kick) begin
        r_timeout <= 1'b0;
      end else if (baud_pulse && fifo_en && !w_empty && (r_tout_cnt == c_tout_max)) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign timeout = r_timeout;
`else
  logic unused_baud;
  assign unused_baud = baud_pulse;
  assign timeout     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_rx_fifo                                              |
// | Description : Self-checking bench for uart_rx_fifo. Directed vector table  |
// |               with hand-computed expected outputs, plus a hand-written     |
// |               character-timeout sequence (UART_RX_TIMEOUT_EN aware).       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst;
  logic       fifo_en;
  logic       clr;
  logic       push;
  logic [7:0] din;
  logic       pe_in;
  logic       fe_in;
  logic       bi_in;
  logic       pop;
  logic       ovr_clr;
  logic [1:0] trig_lvl;
  logic       baud_pulse;
  logic [7:0] dout;
  logic       dout_pe;
  logic       dout_fe;
  logic       dout_bi;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       trig;
  logic       err_in_fifo;
  logic       timeout;

  int n_cmp;
  int n_err;

  uart_rx_fifo #(
    .DEPTH      (16),
    .AW         (4),
    .TOUT_TICKS (640)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_en     (fifo_en),
    .clr         (clr),
    .push        (push),
    .din         (din),
    .pe_in       (pe_in),
    .fe_in       (fe_in),
    .bi_in       (bi_in),
    .pop         (pop),
    .ovr_clr     (ovr_clr),
    .trig_lvl    (trig_lvl),
    .baud_pulse  (baud_pulse),
    .dout        (dout),
    .dout_pe     (dout_pe),
    .dout_fe     (dout_fe),
    .dout_bi     (dout_bi),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .overrun     (overrun),
    .trig        (trig),
    .err_in_fifo (err_in_fifo),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int fen, clr, push, din, pe, fe, bi, pop, oclr, tl;
    int e_dout, e_pe, e_fe, e_bi, e_empty, e_full, e_count, e_ovr, e_trig, e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input int fen, input int c, input int p, input int d,
                   input int pe, input int fe, input int bi, input int po,
                   input int oc, input int tl,
                   input int e_dout, input int e_pe, input int e_fe, input int e_bi,
                   input int e_empty, input int e_full, input int e_count,
                   input int e_ovr, input int e_trig, input int e_err);
    vec_t t;
    t.fen = fen; t.clr = c; t.push = p; t.din = d; t.pe = pe; t.fe = fe;
    t.bi = bi; t.pop = po; t.oclr = oc; t.tl = tl;
    t.e_dout = e_dout; t.e_pe = e_pe; t.e_fe = e_fe; t.e_bi = e_bi;
    t.e_empty = e_empty; t.e_full = e_full; t.e_count = e_count;
    t.e_ovr = e_ovr; t.e_trig = e_trig; t.e_err = e_err;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_strobes();
    push       = 1'b0;
    pop        = 1'b0;
    clr        = 1'b0;
    ovr_clr    = 1'b0;
    baud_pulse = 1'b0;
    pe_in      = 1'b0;
    fe_in      = 1'b0;
    bi_in      = 1'b0;
  endtask

  task automatic apply(input vec_t t, input int idx);
    @(negedge clk);
    fifo_en  = t.fen[0];
    clr      = t.clr[0];
    push     = t.push[0];
    din      = t.din[7:0];
    pe_in    = t.pe[0];
    fe_in    = t.fe[0];
    bi_in    = t.bi[0];
    pop      = t.pop[0];
    ovr_clr  = t.oclr[0];
    trig_lvl = t.tl[1:0];
    @(posedge clk);
    #1;
    clear_strobes();
    chk($sformatf("v%0d dout", idx),    {24'b0, dout},       t.e_dout);
    chk($sformatf("v%0d dout_pe", idx), {31'b0, dout_pe},    t.e_pe);
    chk($sformatf("v%0d dout_fe", idx), {31'b0, dout_fe},    t.e_fe);
    chk($sformatf("v%0d dout_bi", idx), {31'b0, dout_bi},    t.e_bi);
    chk($sformatf("v%0d empty", idx),   {31'b0, empty},      t.e_empty);
    chk($sformatf("v%0d full", idx),    {31'b0, full},       t.e_full);
    chk($sformatf("v%0d count", idx),   {27'b0, count},      t.e_count);
    chk($sformatf("v%0d overrun", idx), {31'b0, overrun},    t.e_ovr);
    chk($sformatf("v%0d trig", idx),    {31'b0, trig},       t.e_trig);
    chk($sformatf("v%0d err", idx),     {31'b0, err_in_fifo}, t.e_err);
    chk($sformatf("v%0d timeout", idx), {31'b0, timeout},    32'd0);
  endtask

  initial begin
    int exp_tout;
    n_cmp = 0;
    n_err = 0;

    // ---------------- vector table ----------------
    //  fen clr push din  pe fe bi pop oclr tl | dout pe fe bi emp full cnt ovr trig err
    v(1,0,0,'h00,0,0,0,0,0,1, 'h00,0,0,0,1,0,0,0,0,0);
    v(1,0,1,'h41,0,0,0,0,0,1, 'h41,0,0,0,0,0,1,0,0,0);
    v(1,0,0,'h00,0,0,0,1,0,1, 'h00,0,0,0,1,0,0,0,0,0);
    for (int k = 1; k <= 16; k++)
      v(1,0,1,k,0,0,0,0,0,1, 'h01,0,0,0,0,(k == 16),k,0,(k >= 4),0);
    v(1,0,1,'hAA,0,0,0,0,0,1, 'h01,0,0,0,0,1,16,1,1,0);
    v(1,0,0,'h00,0,0,0,0,1,1, 'h01,0,0,0,0,1,16,0,1,0);
    v(1,0,1,'h55,0,0,0,1,0,1, 'h02,0,0,0,0,1,16,0,1,0);
    for (int i = 1; i <= 15; i++)
      v(1,0,0,'h00,0,0,0,1,0,1, (i <= 14) ? (2 + i) : 'h55,0,0,0,0,0,16 - i,0,((16 - i) >= 4),0);
    v(1,0,0,'h00,0,0,0,1,0,1, 'h00,0,0,0,1,0,0,0,0,0);
    v(1,0,1,'h77,0,0,0,1,0,1, 'h77,0,0,0,0,0,1,0,0,0);
    v(1,0,0,'h00,0,0,0,1,0,1, 'h00,0,0,0,1,0,0,0,0,0);
    v(1,0,0,'h00,0,0,0,1,0,1, 'h00,0,0,0,1,0,0,0,0,0);
    // error-in-FIFO tracking
    v(1,0,1,'h61,1,0,0,0,0,1, 'h61,1,0,0,0,0,1,0,0,1);
    v(1,0,1,'h62,0,0,0,0,0,1, 'h61,1,0,0,0,0,2,0,0,1);
    v(1,0,1,'h63,0,0,0,0,0,1, 'h61,1,0,0,0,0,3,0,0,1);
    v(1,0,0,'h00,0,0,0,1,0,1, 'h62,0,0,0,0,0,2,0,0,0);
    v(1,0,1,'h64,0,0,1,0,0,1, 'h62,0,0,0,0,0,3,0,0,1);
    v(1,0,0,'h00,0,0,0,1,0,1, 'h63,0,0,0,0,0,2,0,0,1);
    v(1,0,0,'h00,0,0,0,1,0,1, 'h64,0,0,1,0,0,1,0,0,1);
    v(1,0,0,'h00,0,0,0,1,0,1, 'h00,0,0,0,1,0,0,0,0,0);
    // trigger levels and clr
    v(1,0,1,'h71,0,0,0,0,0,0, 'h71,0,0,0,0,0,1,0,1,0);
    v(1,0,0,'h00,0,0,0,0,0,2, 'h71,0,0,0,0,0,1,0,0,0);
    v(1,0,1,'h72,0,0,0,0,0,0, 'h71,0,0,0,0,0,2,0,1,0);
    v(1,1,1,'h99,0,0,0,0,0,0, 'h00,0,0,0,1,0,0,0,0,0);
    // 16450 mode
    v(0,0,0,'h00,0,0,0,0,0,0, 'h00,0,0,0,1,0,0,0,0,0);
    v(0,0,1,'h11,0,0,0,0,0,0, 'h11,0,0,0,0,1,1,0,0,0);
    v(0,0,1,'h22,0,0,0,0,0,0, 'h22,0,0,0,0,1,1,1,0,0);
    v(0,0,0,'h00,0,0,0,0,1,0, 'h22,0,0,0,0,1,1,0,0,0);
    v(0,0,1,'h33,0,0,0,0,1,0, 'h33,0,0,0,0,1,1,1,0,0);
    v(1,0,0,'h00,0,0,0,0,0,0, 'h00,0,0,0,1,0,0,1,0,0);
    v(0,0,0,'h00,0,0,0,0,0,0, 'h00,0,0,0,1,0,0,1,0,0);
    v(0,0,1,'h45,1,0,0,0,0,0, 'h45,1,0,0,0,1,1,1,0,1);
    v(0,0,1,'h46,0,0,0,0,0,0, 'h46,0,0,0,0,1,1,1,0,0);
    v(0,0,0,'h00,0,0,0,1,0,0, 'h00,0,0,0,1,0,0,1,0,0);
    v(0,0,0,'h00,0,0,0,0,1,0, 'h00,0,0,0,1,0,0,0,0,0);
    v(0,0,1,'h47,0,0,0,0,0,0, 'h47,0,0,0,0,1,1,0,0,0);
    v(0,0,1,'h48,0,0,0,1,0,0, 'h48,0,0,0,0,1,1,0,0,0);
    v(0,0,1,'h4A,0,1,0,1,0,0, 'h4A,0,1,0,0,1,1,0,0,1);
    v(0,0,0,'h00,0,0,0,1,0,0, 'h00,0,0,0,1,0,0,0,0,0);
    v(1,0,0,'h00,0,0,0,0,0,1, 'h00,0,0,0,1,0,0,0,0,0);

    // ---------------- reset ----------------
    rst      = 1'b1;
    fifo_en  = 1'b0;
    din      = 8'h00;
    trig_lvl = 2'b00;
    clear_strobes();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset empty",   {31'b0, empty},       32'd1);
    chk("reset full",    {31'b0, full},        32'd0);
    chk("reset count",   {27'b0, count},       32'd0);
    chk("reset overrun", {31'b0, overrun},     32'd0);
    chk("reset trig",    {31'b0, trig},        32'd0);
    chk("reset err",     {31'b0, err_in_fifo}, 32'd0);
    chk("reset timeout", {31'b0, timeout},     32'd0);
    chk("reset dout",    {24'b0, dout},        32'd0);

    foreach (vecs[i]) apply(vecs[i], i);

    // ---------------- character timeout ----------------
    `ifdef UART_RX_TIMEOUT_EN
    exp_tout = 1;
    `else
    exp_tout = 0;
    `endif
    @(negedge clk);
    push = 1'b1;
    din  = 8'h5A;
    @(posedge clk);
    #1;
    push = 1'b0;
    chk("tout count", {27'b0, count}, 32'd1);
    @(negedge clk);
    baud_pulse = 1'b1;
    repeat (639) @(posedge clk);
    #1;
    baud_pulse = 1'b0;
    chk("tout after 639", {31'b0, timeout}, 32'd0);
    @(negedge clk);
    baud_pulse = 1'b1;
    @(posedge clk);
    #1;
    baud_pulse = 1'b0;
    chk("tout after 640", {31'b0, timeout}, exp_tout);
    repeat (3) @(posedge clk);
    #1;
    chk("tout held", {31'b0, timeout}, exp_tout);
    @(negedge clk);
    pop = 1'b1;
    @(posedge clk);
    #1;
    pop = 1'b0;
    chk("tout after pop", {31'b0, timeout}, 32'd0);
    chk("tout pop empty", {31'b0, empty},   32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART16550 receiver. Accepts each received character plus its parity, framing and break flags on the receiver's one-cycle push strobe.
- Stores characters for the register interface (RBR reads) and produces the status LSR/IIR need: data ready, overrun, error-in-FIFO, trigger level reached, character timeout.
- Supports FIFO mode (FCR[0]=1, DEPTH entries) and 16450 mode (FCR[0]=0, single holding register).

Parameters:
- DEPTH, 16, FIFO entries in FIFO mode; power of two, >= 16.
- AW, 4, pointer width, log2(DEPTH).
- TOUT_TICKS, 640, baud_pulse count for character timeout (4 chars × 10 bits × 16).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- fifo_en  in  1  FCR[0]; 1=FIFO mode, 0=single-register mode
- clr  in  1  FCR[1] receive FIFO reset pulse, synchronous
- push  in  1  one-cycle write strobe from receiver
- din  in  8  received character, LSB-aligned for word lengths below 8
- pe_in  in  1  parity error for this character
- fe_in  in  1  framing error for this character
- bi_in  in  1  break indication for this character
- pop  in  1  one-cycle RBR read strobe
- ovr_clr  in  1  LSR read strobe; clears overrun
- trig_lvl  in  2  FCR[7:6]: 00=1, 01=4, 10=8, 11=14 entries
- baud_pulse  in  1  16× baud tick, used for timeout
- dout  out  8  head character (show-ahead)
- dout_pe, dout_fe, dout_bi  out  1 each  head entry error flags
- empty  out  1  no entries (LSR DR = ~empty)
- full  out  1  count==DEPTH (FIFO mode) or count==1 (16450 mode)
- count  out  AW+1  current occupancy
- overrun  out  1  sticky overrun (LSR OE)
- trig  out  1  count >= selected trigger level, FIFO mode only
- err_in_fifo  out  1  at least one stored entry has pe|fe|bi (LSR[7])
- timeout  out  1  character timeout indication

Behaviour:
- Reset: pointers=0, count=0, empty=1, full=0, overrun=0, trig=0, err_in_fifo=0, timeout=0. Memory contents are don't-care. dout and flags read 0 while empty.
- Entry is 11 bits: {bi,fe,pe,din}. dout and flags are taken combinationally from mem[rptr]; no read latency. Pop advances rptr at the clock edge.
- Write: push and not full → mem[wptr]<=entry, wptr++, count++. Pointers wrap modulo DEPTH.
- Push while full, no pop: entry is discarded, overrun<=1, stored data is unchanged. In 16450 mode (depth 1), push while full instead overwrites the holding register and sets overrun.
- Pop while empty: ignored; no pointer or count change.
- Push and pop in the same cycle:
  - Non-empty, not full: both occur, count unchanged.
  - Full: both occur, no overrun.
  - Empty: only the push occurs.
- overrun clears on ovr_clr. If ovr_clr and a new overrun event occur in the same cycle, overrun=1 (set wins).
- err_in_fifo: maintain an error-entry counter. Increment on accepted push with any flag set; decrement on pop of a head entry with any flag set; both in the same cycle → unchanged. err_in_fifo = counter!=0.
- trig: FIFO mode only; 0 in 16450 mode. Thresholds 1/4/8/14 compared against count.
- clr, or any change of fifo_en (edge detected internally): pointers, count and error counter cleared, timeout cleared. overrun is preserved. A push in the same cycle as clr is dropped.
- Timeout is covered by the optional feature below.

Optional Feature:
- Macro UART_RX_TIMEOUT_EN.
- Defined:
  - A timeout counter increments on baud_pulse while FIFO mode && !empty.
  - It resets to 0 on push, pop, clr, or when empty.
  - timeout<=1 when the counter reaches TOUT_TICKS-1 on a baud_pulse. It holds until the next push, pop or clr.
  - The counter saturates and does not wrap.
- Undefined: timeout tied to 0, no counter logic.

Test Plan:
- Reset, then push din=0x41 (no errors) → empty=0, count=1, dout=0x41. Pop → empty=1, count=0.
- FIFO mode, trig_lvl=01, push 0x01..0x04 → trig rises in the cycle after the 4th push. Push 0x05..0x10 (16 total) → full=1. Push 0xAA → overrun=1, dout still 0x01. ovr_clr → overrun=0.
- Push with pe_in=1 then 2 clean pushes → err_in_fifo=1. Pop first entry (dout_pe=1) → err_in_fifo=0 next cycle.
- Full FIFO, push 0x55 and pop in the same cycle → overrun=0, count=16, tail entry=0x55. Empty FIFO, push+pop same cycle → count=1.
- fifo_en=0: push 0x11, push 0x22 → overrun=1, dout=0x22, full=1, trig=0. Toggle fifo_en → count=0, overrun still 1.
- With UART_RX_TIMEOUT_EN and TOUT_TICKS=640: one push, then 639 baud_pulses → timeout=0; 640th → timeout=1; pop → timeout=0. Without the macro → timeout=0 throughout.
